imem_line_server: RTL and testbench
===================================

Name: imem_line_server

Overview:
- Memory-side responder for the core's instruction-fetch interface.
- Takes fetch addresses from the fetch stage and returns instruction words.
- Serves words from a single-line fetch buffer. On a miss, refills the line from a backing memory over a req/ack bus.
- Sits between the fetch stage and the shared memory/bus, and owns the fetch-side response protocol.

Parameters:
LINE_WORDS, 4, words per line buffer; power of two, 2 to 16.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
imem_req  input  1  fetch request valid
imem_addr  input  32  fetch byte address
imem_valid  output  1  response valid, one-cycle pulse per accepted request
imem_data  output  32  instruction word; meaningful only while imem_valid=1
imem_fault  output  1  misaligned-fetch flag; qualifies imem_valid
invalidate  input  1  discard line buffer contents (fence.i)
mem_req  output  1  backing read request
mem_addr  output  32  backing word address, byte-addressed, bits[1:0]=0
mem_ack  input  1  backing read data valid
mem_rdata  input  32  backing read data

Behaviour:
- Clock and reset: reset is synchronous and active-high; all state changes on posedge clk.
- Reset values: imem_valid=0, imem_data=0, imem_fault=0, mem_req=0, mem_addr=0, line valid=0, tag=0, state=IDLE, word counter=0. Reset mid-refill aborts the refill; mem_req=0 from the reset edge onward, and the backing memory must tolerate the abandoned request.
- Line base address: base = imem_addr with the low log2(LINE_WORDS*4) bits cleared. Tag = the remaining upper address bits.
- States: IDLE, REFILL.
- IDLE, imem_req=1, imem_addr[1:0]!=0:
  - Next cycle: imem_valid=1, imem_fault=1, imem_data=0.
  - No backing access; state stays IDLE.
- IDLE, imem_req=1, aligned, line valid, tag match, invalidate=0 (hit):
  - Next cycle: imem_valid=1, imem_fault=0, imem_data=buffered word.
  - Latency 1; throughput 1 per cycle.
- IDLE, imem_req=1, aligned, miss (or invalidate=1 in the same cycle):
  - Latch request address; clear line valid; go to REFILL.
  - Next cycle: mem_req=1, mem_addr=base.
- REFILL:
  - mem_req and mem_addr stay stable until mem_ack=1.
  - On ack: store mem_rdata at the counter index. If more words remain, next cycle mem_addr += 4 with mem_req still 1 (single outstanding request).
  - On the ack of the last word:
    - mem_req=0 next cycle.
    - Line valid set (unless invalidate was seen during the refill), tag written.
    - imem_valid=1 next cycle with the latched word; this may equal the final mem_rdata, which is forwarded.
    - state -> IDLE.
- Miss latency with zero-wait memory (ack in the same cycle as req): request at cycle 0, mem_req cycles 1..LINE_WORDS, imem_valid at cycle LINE_WORDS+1.
- Requests during REFILL: imem_req and imem_addr are ignored; the latched address is served.
- Back-to-back requests: a request present in the cycle imem_valid=1 while in IDLE is a new request and is evaluated that cycle.
- invalidate:
  - In IDLE: clears line valid at the edge, and overrides a simultaneous hit.
  - In REFILL: the refill completes and serves its request, but line valid stays 0 afterwards.
- Address top: the line at 0xFFFFFFF0 refills words 0xFFFFFFF0..0xFFFFFFFC. mem_addr increments only within the line index bits, with no carry into the tag.
- Outputs are registered; there is no combinational path from imem_* inputs to imem_* outputs.

Test Plan:
- Cold miss, zero-wait memory returning addr^0xA5A5A5A5: imem_req at 0x100 -> mem_req at 0x100/104/108/10C on consecutive cycles; imem_valid at cycle 5 with data 0xA5A5A4A5; fault=0.
- Hits after cold fill: requests 0x104, 0x108, 0x10C on consecutive cycles -> imem_valid on 3 consecutive cycles with the matching words; mem_req stays 0.
- Misaligned request at 0x102 -> next cycle imem_valid=1, imem_fault=1, imem_data=0; no mem_req.
- Wait states: 3-cycle mem_ack delay on each word -> mem_addr held stable; imem_valid 17 cycles after the request; imem_addr changed during the refill is ignored.
- Invalidate asserted together with a hit request at 0x100 -> a refill is issued. Invalidate pulsed mid-refill -> the request is served, and the next request to 0x104 refills again.
- Reset asserted during the second refill word -> mem_req=0 and imem_valid=0 next cycle; a subsequent request at 0x100 misses. A request at 0xFFFFFFFC refills 0xFFFFFFF0..0xFFFFFFFC with no wrap to 0x0.

Source files
------------

// File: rtl/imem_line_server.sv
// rtl/imem_line_server.sv - instruction-fetch responder with a single-line buffer refilled over a req/ack bus
module imem_line_server #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_valid,
    output logic [31:0] imem_data,
    output logic        imem_fault,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int IDX_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS = IDX_BITS + 2;
    localparam int TAG_BITS = 32 - OFF_BITS;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t              r_state;
    logic [31:0]         r_line [LINE_WORDS];
    logic                r_line_valid;
    logic [TAG_BITS-1:0] r_tag;
    logic [TAG_BITS-1:0] r_req_tag;
    logic [IDX_BITS-1:0] r_req_idx;
    logic [IDX_BITS-1:0] r_cnt;
    logic                r_inv_seen;
    logic                r_imem_valid;
    logic [31:0]         r_imem_data;
    logic                r_imem_fault;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;

    logic [TAG_BITS-1:0] w_req_tag;
    logic [IDX_BITS-1:0] w_req_idx;
    logic [IDX_BITS-1:0] w_cnt_next;
    logic                w_hit;
    logic                w_last;

    assign w_req_tag  = imem_addr[31:OFF_BITS];
    assign w_req_idx  = imem_addr[OFF_BITS-1:2];
    assign w_cnt_next = r_cnt + IDX_BITS'(1);
    assign w_hit      = r_line_valid && (r_tag == w_req_tag) && !invalidate;
    assign w_last     = (r_cnt == IDX_BITS'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_line_valid <= 1'b0;
            r_tag        <= '0;
            r_req_tag    <= '0;
            r_req_idx    <= '0;
            r_cnt        <= '0;
            r_inv_seen   <= 1'b0;
            r_imem_valid <= 1'b0;
            r_imem_data  <= '0;
            r_imem_fault <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            r_imem_valid <= 1'b0;
            r_imem_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (invalidate)
                        r_line_valid <= 1'b0;
                    if (imem_req) begin
                        if (imem_addr[1:0] != 2'b00) begin
                            r_imem_valid <= 1'b1;
                            r_imem_fault <= 1'b1;
                            r_imem_data  <= '0;
                        end else if (w_hit) begin
                            r_imem_valid <= 1'b1;
                            r_imem_data  <= r_line[w_req_idx];
                        end else begin
                            r_req_tag    <= w_req_tag;
                            r_req_idx    <= w_req_idx;
                            r_line_valid <= 1'b0;
                            r_cnt        <= '0;
                            r_inv_seen   <= 1'b0;
                            r_mem_req    <= 1'b1;
                            r_mem_addr   <= {w_req_tag, {OFF_BITS{1'b0}}};
                            r_state      <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (invalidate)
                        r_inv_seen <= 1'b1;
                    if (mem_ack) begin
                        r_line[r_cnt] <= mem_rdata;
                        if (w_last) begin
                            r_mem_req    <= 1'b0;
                            r_line_valid <= !(r_inv_seen || invalidate);
                            r_tag        <= r_req_tag;
                            r_imem_valid <= 1'b1;
                            // The requested word may be the one arriving this cycle.
                            r_imem_data  <= (r_req_idx == r_cnt) ? mem_rdata : r_line[r_req_idx];
                            r_state      <= IDLE;
                        end else begin
                            // Index field wraps inside the line; the tag never carries.
                            r_cnt      <= w_cnt_next;
                            r_mem_addr <= {r_req_tag, w_cnt_next, 2'b00};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_valid = r_imem_valid;
    assign imem_data  = r_imem_data;
    assign imem_fault = r_imem_fault;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
endmodule

// File: tb/tb_imem_line_server.sv
// tb/tb_imem_line_server.sv - scoreboard bench for imem_line_server
module tb_imem_line_server;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        imem_fault;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    imem_line_server #(.LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .imem_fault(imem_fault),
        .invalidate(invalidate),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic fault; int at; } exp_t;
    typedef struct { int at; logic [31:0] addr; } mreq_t;
    exp_t  sb[$];
    exp_t  e;
    mreq_t mlog[$];
    int n_vec = 0;
    int n_err = 0;
    int wait_states = 0;
    int wcnt = 0;
    int mreq_cycles = 0;
    int addr_unstable = 0;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;

    // Backing memory: answers addr^K after wait_states idle cycles per word.
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            mreq_cycles++;
            if (prev_pending && mem_addr !== prev_addr) addr_unstable++;
            if (wcnt >= wait_states) begin
                mem_ack = 1'b1;
                mem_rdata = mem_addr ^ K;
                mlog.push_back('{cyc, mem_addr});
                wcnt = 0;
                prev_pending = 1'b0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 32'hDEADBEEF;
                wcnt++;
                prev_pending = 1'b1;
                prev_addr = mem_addr;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
            prev_pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (imem_valid === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_resp: got data=%h fault=%b at cyc %0d, expected no response", imem_data, imem_fault, cyc);
            end else begin
                e = sb.pop_front();
                if (imem_data !== e.data || imem_fault !== e.fault || cyc != e.at) begin
                    n_err++;
                    $display("FAIL resp: got data=%h fault=%b cyc=%0d, expected data=%h fault=%b cyc=%0d",
                             imem_data, imem_fault, cyc, e.data, e.fault, e.at);
                end
            end
        end
    end

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic f, input int lat);
        @(negedge clk);
        imem_req = 1'b1;
        imem_addr = a;
        sb.push_back('{d, f, cyc + lat});
        @(negedge clk);
        imem_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({imem_valid, imem_fault, mem_req} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid/fault/mem_req=%b%b%b, expected 000", imem_valid, imem_fault, mem_req);
        end
        n_vec++;
        if (imem_data !== 32'h0 || mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got imem_data=%h mem_addr=%h, expected 0 0", imem_data, mem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        int n0;
        wait_states = 0;
        mlog.delete();
        @(negedge clk);
        n0 = cyc;
        imem_req = 1'b1;
        imem_addr = 32'h100;
        sb.push_back('{32'hA5A5A4A5, 1'b0, n0 + 5});
        @(negedge clk);
        imem_req = 1'b0;
        drain(20, "cold_miss");
        n_vec++;
        if (mlog.size() != 4) begin
            n_err++;
            $display("FAIL cold_miss_count: got %0d backing reads, expected 4", mlog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (mlog[k].addr !== 32'h100 + 32'(4 * k) || mlog[k].at != n0 + 1 + k) begin
                    n_err++;
                    $display("FAIL cold_miss_read%0d: got addr=%h cyc=%0d, expected addr=%h cyc=%0d",
                             k, mlog[k].addr, mlog[k].at, 32'h100 + 32'(4 * k), n0 + 1 + k);
                end
            end
        end
    endtask

    task automatic test_hits();
        int m0;
        logic [31:0] a;
        m0 = mreq_cycles;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            a = 32'h100 + 32'(4 * k);
            imem_req = 1'b1;
            imem_addr = a;
            sb.push_back('{a ^ K, 1'b0, cyc + 1});
        end
        @(negedge clk);
        imem_req = 1'b0;
        drain(10, "hits");
        n_vec++;
        if (mreq_cycles != m0) begin
            n_err++;
            $display("FAIL hits_no_mem: got %0d mem_req cycles, expected 0", mreq_cycles - m0);
        end
    endtask

    task automatic test_misaligned();
        int m0;
        m0 = mreq_cycles;
        issue(32'h102, 32'h0, 1'b1, 1);
        issue(32'h10C, 32'h10C ^ K, 1'b0, 1);
        drain(10, "misaligned");
        n_vec++;
        if (mreq_cycles != m0) begin
            n_err++;
            $display("FAIL misaligned_no_mem: got %0d mem_req cycles, expected 0", mreq_cycles - m0);
        end
    endtask

    task automatic test_wait_states();
        int n0;
        wait_states = 3;
        addr_unstable = 0;
        mlog.delete();
        @(negedge clk);
        n0 = cyc;
        imem_req = 1'b1;
        imem_addr = 32'h200;
        sb.push_back('{32'h200 ^ K, 1'b0, n0 + 17});
        @(negedge clk);
        imem_addr = 32'h300;
        repeat (8) @(negedge clk);
        imem_req = 1'b0;
        drain(40, "wait_states");
        n_vec++;
        if (addr_unstable != 0) begin
            n_err++;
            $display("FAIL wait_addr_stable: got %0d address changes while waiting, expected 0", addr_unstable);
        end
        n_vec++;
        if (mlog.size() != 4) begin
            n_err++;
            $display("FAIL wait_count: got %0d backing reads, expected 4", mlog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (mlog[k].addr !== 32'h200 + 32'(4 * k) || mlog[k].at != n0 + 4 + 4 * k) begin
                    n_err++;
                    $display("FAIL wait_read%0d: got addr=%h cyc=%0d, expected addr=%h cyc=%0d",
                             k, mlog[k].addr, mlog[k].at, 32'h200 + 32'(4 * k), n0 + 4 + 4 * k);
                end
            end
        end
        wait_states = 0;
        issue(32'h208, 32'h208 ^ K, 1'b0, 1);
        drain(10, "wait_hit");
    endtask

    task automatic test_invalidate();
        int m0;
        m0 = mreq_cycles;
        @(negedge clk);
        imem_req = 1'b1;
        imem_addr = 32'h200;
        invalidate = 1'b1;
        sb.push_back('{32'h200 ^ K, 1'b0, cyc + 5});
        @(negedge clk);
        imem_req = 1'b0;
        invalidate = 1'b0;
        drain(20, "inv_hit");
        n_vec++;
        if (mreq_cycles - m0 != 4) begin
            n_err++;
            $display("FAIL inv_hit_refill: got %0d mem_req cycles, expected 4", mreq_cycles - m0);
        end
        @(negedge clk);
        imem_req = 1'b1;
        imem_addr = 32'h100;
        sb.push_back('{32'h100 ^ K, 1'b0, cyc + 5});
        @(negedge clk);
        imem_req = 1'b0;
        @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        drain(20, "inv_mid");
        m0 = mreq_cycles;
        issue(32'h104, 32'h104 ^ K, 1'b0, 5);
        drain(20, "inv_after");
        n_vec++;
        if (mreq_cycles - m0 != 4) begin
            n_err++;
            $display("FAIL inv_mid_refill_again: got %0d mem_req cycles, expected 4", mreq_cycles - m0);
        end
    endtask

    task automatic test_reset_abort();
        int m0;
        @(negedge clk);
        imem_req = 1'b1;
        imem_addr = 32'h400;
        @(negedge clk);
        imem_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mem_req !== 1'b0 || imem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: got mem_req=%b imem_valid=%b, expected 0 0", mem_req, imem_valid);
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        m0 = mreq_cycles;
        issue(32'h100, 32'h100 ^ K, 1'b0, 5);
        drain(20, "after_reset");
        n_vec++;
        if (mreq_cycles - m0 != 4) begin
            n_err++;
            $display("FAIL after_reset_miss: got %0d mem_req cycles, expected 4", mreq_cycles - m0);
        end
    endtask

    task automatic test_top_address();
        int m0;
        mlog.delete();
        issue(32'hFFFFFFFC, 32'h5A5A5A59, 1'b0, 5);
        drain(20, "top");
        n_vec++;
        if (mlog.size() != 4) begin
            n_err++;
            $display("FAIL top_count: got %0d backing reads, expected 4", mlog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (mlog[k].addr !== 32'hFFFFFFF0 + 32'(4 * k)) begin
                    n_err++;
                    $display("FAIL top_read%0d: got addr=%h, expected %h", k, mlog[k].addr, 32'hFFFFFFF0 + 32'(4 * k));
                end
            end
        end
        m0 = mreq_cycles;
        issue(32'hFFFFFFF0, 32'h5A5A5A55, 1'b0, 1);
        drain(10, "top_hit");
        n_vec++;
        if (mreq_cycles != m0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL top_no_wrap: got %0d extra mem_req cycles mem_req=%b, expected 0 0", mreq_cycles - m0, mem_req);
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_req = 1'b0;
        imem_addr = '0;
        invalidate = 1'b0;
        test_reset();
        test_cold_miss();
        test_hits();
        test_misaligned();
        test_wait_states();
        test_invalidate();
        test_reset_abort();
        test_top_address();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
